// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants, coordinate type and sync-window helper,
// shared by the sync generator and the overlay blocks.
package vga_timing_pkg;

  localparam int COORD_W   = 10;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_t;

  // Compared as int so a window ending exactly at 1024 still decodes.
  function automatic logic in_window(coord_t v, int lo, int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Mod-CLK_DIV divider producing the one-cycle pixel enable.
module pixel_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_en,
  output logic p_tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic          p_tick_q, p_tick_d;

  // tick_en is the next-state view of p_tick so the counters can load
  // on the same edge that raises p_tick.
  always_comb begin
    tick_en  = (div_q == DW'(CLK_DIV - 1));
    div_d    = tick_en ? '0 : div_q + DW'(1);
    p_tick_d = tick_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      p_tick_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      p_tick_q <= p_tick_d;
    end
  end

  assign p_tick = p_tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA pixel/line counters with registered hsync/vsync/video_on and frame_start.
// rst_n is expected to be released synchronously to clk by the reset tree.
module vga_sync_gen #(
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK,
  parameter int CLK_DIV   = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  output logic                               p_tick,
  output logic [vga_timing_pkg::COORD_W-1:0] x,
  output logic [vga_timing_pkg::COORD_W-1:0] y,
  output logic                               hsync,
  output logic                               vsync,
  output logic                               video_on,
  output logic                               frame_start
);
  import vga_timing_pkg::*;

  localparam int H_TOT    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT    = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam sync_t SYNC_RST = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b1};

  logic   tick_en;
  coord_t x_q, x_d;
  coord_t y_q, y_d;
  sync_t  sync_q, sync_d;
  logic   fs_q, fs_d;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_en (tick_en),
    .p_tick  (p_tick)
  );

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    fs_d = 1'b0;
    if (tick_en) begin
      if (x_q == coord_t'(H_TOT - 1)) begin
        x_d = '0;
        if (y_q == coord_t'(V_TOT - 1)) begin
          y_d  = '0;
          fs_d = 1'b1;
        end else begin
          y_d = y_q + coord_t'(1);
        end
      end else begin
        x_d = x_q + coord_t'(1);
      end
    end
    // Decode from next-state coordinates so sync lines up with x/y.
    sync_d.hsync    = !in_window(x_d, HS_START, HS_END);
    sync_d.vsync    = !in_window(y_d, VS_START, VS_END);
    sync_d.video_on = in_window(x_d, 0, H_DISPLAY) && in_window(y_d, 0, V_DISPLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      sync_q <= SYNC_RST;
      fs_q   <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      sync_q <= sync_d;
      fs_q   <= fs_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = sync_q.hsync;
  assign vsync       = sync_q.vsync;
  assign video_on    = sync_q.video_on;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default geometry for one line, plus a reduced
// geometry at CLK_DIV=2 and CLK_DIV=1 for whole frames and random resets.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int k;
  int total = 0;
  int bad = 0;

  logic p_d, fs_d, hs_d, vs_d, vo_d;
  logic [9:0] x_d, y_d;
  logic p_2, fs_2, hs_2, vs_2, vo_2;
  logic [9:0] x_2, y_2;
  logic p_1, fs_1, hs_1, vs_1, vo_1;
  logic [9:0] x_1, y_1;

  vga_sync_gen u_def (
    .clk(clk), .rst_n(rst_n), .p_tick(p_d), .x(x_d), .y(y_d),
    .hsync(hs_d), .vsync(vs_d), .video_on(vo_d), .frame_start(fs_d)
  );

  vga_sync_gen #(
    .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
    .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .CLK_DIV(2)
  ) u_s2 (
    .clk(clk), .rst_n(rst_n), .p_tick(p_2), .x(x_2), .y(y_2),
    .hsync(hs_2), .vsync(vs_2), .video_on(vo_2), .frame_start(fs_2)
  );

  vga_sync_gen #(
    .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
    .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .CLK_DIV(1)
  ) u_s1 (
    .clk(clk), .rst_n(rst_n), .p_tick(p_1), .x(x_1), .y(y_1),
    .hsync(hs_1), .vsync(vs_1), .video_on(vo_1), .frame_start(fs_1)
  );

  wire [24:0] o_def = {p_d, fs_d, hs_d, vs_d, vo_d, x_d, y_d};
  wire [24:0] o_s2  = {p_2, fs_2, hs_2, vs_2, vo_2, x_2, y_2};
  wire [24:0] o_s1  = {p_1, fs_1, hs_1, vs_1, vo_1, x_1, y_1};

  localparam logic [24:0] RST_VEC = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0};

  // Reference: after kk clk edges out of reset, kk/d pixel ticks have
  // elapsed; position is that tick count folded onto the raster.
  function automatic logic [24:0] model(int kk, int hd, int hf, int hs, int hb,
                                        int vd, int vf, int vs, int vb, int d);
    int ht, vt, n, xx, yy;
    logic p, fs, hsn, vsn, von;
    ht  = hd + hf + hs + hb;
    vt  = vd + vf + vs + vb;
    n   = kk / d;
    xx  = n % ht;
    yy  = (n / ht) % vt;
    p   = (kk >= 1) && (kk % d == 0);
    fs  = p && (n % (ht * vt) == 0);
    hsn = !(xx >= hd + hf && xx < hd + hf + hs);
    vsn = !(yy >= vd + vf && yy < vd + vf + vs);
    von = (xx < hd) && (yy < vd);
    return {p, fs, hsn, vsn, von, xx[9:0], yy[9:0]};
  endfunction

  function automatic logic [24:0] exp_def(int kk);
    return model(kk, 640, 16, 96, 48, 480, 10, 2, 33, 2);
  endfunction
  function automatic logic [24:0] exp_s2(int kk);
    return model(kk, 16, 4, 6, 4, 8, 2, 2, 3, 2);
  endfunction
  function automatic logic [24:0] exp_s1(int kk);
    return model(kk, 16, 4, 6, 4, 8, 2, 2, 3, 1);
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst_n) k++;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    k = 0;
    step();
    step();
    total++; if (o_def !== RST_VEC) begin bad++; $display("FAIL reset_def got=%h exp=%h", o_def, RST_VEC); end
    total++; if (o_s2 !== RST_VEC) begin bad++; $display("FAIL reset_s2 got=%h exp=%h", o_s2, RST_VEC); end
    total++; if (o_s1 !== RST_VEC) begin bad++; $display("FAIL reset_s1 got=%h exp=%h", o_s1, RST_VEC); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      // CLK_DIV=2: first p_tick on the 2nd edge after release, then every 2nd
      total++; if (p_2 !== ((i % 2) == 0)) begin bad++; $display("FAIL first_tick_s2 edge=%0d got=%b exp=%b", i, p_2, (i % 2) == 0); end
      total++; if (o_s2 !== exp_s2(k)) begin bad++; $display("FAIL release_s2 k=%0d got=%h exp=%h", k, o_s2, exp_s2(k)); end
    end
  endtask

  task automatic test_line();
    int hs_cnt, hs_first, vo_fall, y_after, prev_x;
    bit wrapped;
    hs_cnt = 0; hs_first = -1; vo_fall = -1; y_after = -1; prev_x = int'(x_d);
    wrapped = 1'b0;
    for (int i = 0; i < 1650 && !wrapped; i++) begin
      step();
      total++; if (o_def !== exp_def(k)) begin bad++; $display("FAIL line_def k=%0d got=%h exp=%h", k, o_def, exp_def(k)); end
      if (p_d) begin
        if (y_d == 10'd0 && !hs_d) begin
          if (hs_cnt == 0) hs_first = int'(x_d);
          hs_cnt++;
        end
        if (y_d == 10'd0 && !vo_d && vo_fall < 0) vo_fall = int'(x_d);
        if (x_d == 10'd0 && prev_x == 799) begin
          y_after = int'(y_d);
          wrapped = 1'b1;
        end
        prev_x = int'(x_d);
      end
    end
    total++; if (!wrapped) begin bad++; $display("FAIL line_wrap_timeout got=0 exp=1"); end
    total++; if (hs_cnt != 96) begin bad++; $display("FAIL hsync_width got=%0d exp=96", hs_cnt); end
    total++; if (hs_first != 656) begin bad++; $display("FAIL hsync_start got=%0d exp=656", hs_first); end
    total++; if (vo_fall != 640) begin bad++; $display("FAIL video_on_fall got=%0d exp=640", vo_fall); end
    total++; if (y_after != 1) begin bad++; $display("FAIL y_step got=%0d exp=1", y_after); end
  endtask

  task automatic test_frames();
    int fs2_k[$];
    int fs1_k[$];
    int vs_low, last_wrap1, line_per1;
    vs_low = 0; last_wrap1 = -1; line_per1 = -1;
    for (int i = 0; i < 3000 && fs2_k.size() < 3; i++) begin
      step();
      total++; if (o_s2 !== exp_s2(k)) begin bad++; $display("FAIL frame_s2 k=%0d got=%h exp=%h", k, o_s2, exp_s2(k)); end
      total++; if (o_s1 !== exp_s1(k)) begin bad++; $display("FAIL frame_s1 k=%0d got=%h exp=%h", k, o_s1, exp_s1(k)); end
      total++;
      if (x_2 >= 10'd30 || y_2 >= 10'd15 || vo_2 !== (x_2 < 10'd16 && y_2 < 10'd8)) begin
        bad++; $display("FAIL bounds_s2 x=%0d y=%0d vo=%b", x_2, y_2, vo_2);
      end
      total++;
      if (x_1 >= 10'd30 || y_1 >= 10'd15 || vo_1 !== (x_1 < 10'd16 && y_1 < 10'd8)) begin
        bad++; $display("FAIL bounds_s1 x=%0d y=%0d vo=%b", x_1, y_1, vo_1);
      end
      if (fs_2) fs2_k.push_back(k);
      if (fs_1) fs1_k.push_back(k);
      if (fs2_k.size() == 1 && p_2 && !vs_2) vs_low++;
      if (p_1 && x_1 == 10'd0) begin
        if (last_wrap1 >= 0) line_per1 = k - last_wrap1;
        last_wrap1 = k;
      end
    end
    total++; if (fs2_k.size() < 3) begin bad++; $display("FAIL frame_timeout got=%0d exp=3", fs2_k.size()); end
    else begin
      total++; if (fs2_k[1] - fs2_k[0] != 900) begin bad++; $display("FAIL frame_period_s2 got=%0d exp=900", fs2_k[1] - fs2_k[0]); end
      total++; if (fs2_k[2] - fs2_k[1] != 900) begin bad++; $display("FAIL frame_period2_s2 got=%0d exp=900", fs2_k[2] - fs2_k[1]); end
      total++; if (vs_low != 60) begin bad++; $display("FAIL vsync_ticks got=%0d exp=60", vs_low); end
    end
    total++; if (fs1_k.size() < 2 || fs1_k[1] - fs1_k[0] != 450) begin
      bad++; $display("FAIL frame_period_s1 got=%0d exp=450", fs1_k.size() < 2 ? -1 : fs1_k[1] - fs1_k[0]);
    end
    total++; if (line_per1 != 30) begin bad++; $display("FAIL line_period_s1 got=%0d exp=30", line_per1); end
  endtask

  task automatic test_clkdiv1();
    for (int i = 0; i < 40; i++) begin
      step();
      total++; if (p_1 !== 1'b1) begin bad++; $display("FAIL p_tick_const_s1 k=%0d got=%b exp=1", k, p_1); end
    end
  endtask

  task automatic test_mid_reset();
    int run, hold;
    for (int r = 0; r < 3; r++) begin
      run  = int'($urandom_range(50, 700));
      hold = int'($urandom_range(1, 4));
      for (int i = 0; i < run; i++) begin
        step();
        total++; if (o_def !== exp_def(k)) begin bad++; $display("FAIL pre_rst_def k=%0d got=%h exp=%h", k, o_def, exp_def(k)); end
        total++; if (o_s2 !== exp_s2(k)) begin bad++; $display("FAIL pre_rst_s2 k=%0d got=%h exp=%h", k, o_s2, exp_s2(k)); end
      end
      #2 rst_n = 1'b0;
      #1;
      // Still before the next active edge: reset must already be visible.
      total++; if (o_def !== RST_VEC) begin bad++; $display("FAIL async_rst_def got=%h exp=%h", o_def, RST_VEC); end
      total++; if (o_s2 !== RST_VEC) begin bad++; $display("FAIL async_rst_s2 got=%h exp=%h", o_s2, RST_VEC); end
      total++; if (o_s1 !== RST_VEC) begin bad++; $display("FAIL async_rst_s1 got=%h exp=%h", o_s1, RST_VEC); end
      k = 0;
      for (int i = 0; i < 3; i++) begin
        step();
        total++; if (o_s2 !== RST_VEC) begin bad++; $display("FAIL rst_hold_s2 got=%h exp=%h", o_s2, RST_VEC); end
      end
      for (int i = 0; i < hold; i++) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 1000; i++) begin
        step();
        total++; if (o_s2 !== exp_s2(k)) begin bad++; $display("FAIL restart_s2 k=%0d got=%h exp=%h", k, o_s2, exp_s2(k)); end
        total++; if (o_s1 !== exp_s1(k)) begin bad++; $display("FAIL restart_s1 k=%0d got=%h exp=%h", k, o_s1, exp_s1(k)); end
        total++; if (o_def !== exp_def(k)) begin bad++; $display("FAIL restart_def k=%0d got=%h exp=%h", k, o_def, exp_def(k)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frames();
    test_clkdiv1();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
